// File: rtl/adder_bitserial_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial add/subtract sequencer.
// master: requester + consumer side; slave: the sequencer itself.
interface adder_bitserial_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
);

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             busy;
  logic [CNT_W-1:0] bit_idx;

  modport master (
    output in_valid, op_sub, A, B, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf, busy, bit_idx
  );

  modport slave (
    input  in_valid, op_sub, A, B, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf, busy, bit_idx
  );

endinterface

// File: rtl/adder_bitserial_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell evaluated WIDTH times,
// LSB first, with the carry held in a flop and the result built in a shift register.
module adder_bitserial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  adder_bitserial_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_a, cell_b, cell_sum, cell_cout;

  // Full-adder cell fed from the operand LSBs and the stored carry.
  always_comb begin
    cell_a    = opa_q[0];
    cell_b    = opb_q[0];
    cell_sum  = cell_a ^ cell_b ^ carry_q;
    cell_cout = (cell_a & cell_b) | (carry_q & (cell_a ^ cell_b));
  end

  // Sequencer next-state: accept in IDLE, one bit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          opa_d   = bus.A;
          // Subtract as A + ~B + 1: the +1 enters through the initial carry.
          opb_d   = bus.op_sub ? ~bus.B : bus.B;
          carry_d = bus.op_sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = cell_sum;
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        carry_d          = cell_cout;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cout_d  = cell_cout;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ cell_cout;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset also discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.bit_idx   = (state_q == StRun) ? cnt_q : '0;
    bus.Sum       = sum_q;
    bus.Cout      = cout_q;
    bus.Ovf       = ovf_q;
  end

endmodule

// File: tb/tb_adder_bitserial_ctrl.sv
// Directed bench for adder_bitserial_ctrl: WIDTH=8 vector table plus
// hand sequences for backpressure, mid-op reset and a WIDTH=1 instance.
module tb_adder_bitserial_ctrl;

  logic clk;
  logic rst;

  adder_bitserial_ctrl_if #(.WIDTH(8)) bus8 ();
  adder_bitserial_ctrl_if #(.WIDTH(1)) bus1 ();

  adder_bitserial_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  adder_bitserial_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 operation; leaves the result pending in DONE when rel=0.
  task automatic do_op8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input logic rel, input string tag);
    int   lat;
    logic idx_ok;
    @(negedge clk);
    bus8.in_valid  = 1'b1;
    bus8.op_sub    = sub;
    bus8.A         = a;
    bus8.B         = b;
    bus8.out_ready = rel;
    chk({tag, " in_ready before accept"}, bus8.in_ready, 1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    lat    = 0;
    idx_ok = 1'b1;
    while (!bus8.out_valid && lat < 40) begin
      if (bus8.bit_idx !== 3'(lat) || bus8.busy !== 1'b1) idx_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 8);
    chk({tag, " bit_idx sequence"}, idx_ok, 1);
    chk({tag, " Sum"}, bus8.Sum, es);
    chk({tag, " Cout"}, bus8.Cout, ec);
    chk({tag, " Ovf"}, bus8.Ovf, eo);
    chk({tag, " in_ready in DONE"}, bus8.in_ready, 0);
    chk({tag, " bit_idx in DONE"}, bus8.bit_idx, 0);
    if (rel) begin
      @(posedge clk);
      #1;
      chk({tag, " out_valid after handshake"}, bus8.out_valid, 0);
      chk({tag, " in_ready after handshake"}, bus8.in_ready, 1);
      chk({tag, " busy after handshake"}, bus8.busy, 0);
      chk({tag, " Sum held in IDLE"}, bus8.Sum, es);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'hC3, 8'hA5, 8'h68, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.op_sub    = 1'b0;
    bus8.A         = '0;
    bus8.B         = '0;
    bus8.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.op_sub    = 1'b0;
    bus1.A         = '0;
    bus1.B         = '0;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of both instances.
    chk("reset in_ready", bus8.in_ready, 1);
    chk("reset out_valid", bus8.out_valid, 0);
    chk("reset busy", bus8.busy, 0);
    chk("reset bit_idx", bus8.bit_idx, 0);
    chk("reset Sum", bus8.Sum, 0);
    chk("reset Cout", bus8.Cout, 0);
    chk("reset Ovf", bus8.Ovf, 0);
    chk("reset w1 in_ready", bus1.in_ready, 1);
    chk("reset w1 out_valid", bus1.out_valid, 0);

    for (int i = 0; i < 11; i++) begin
      do_op8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             1'b1, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE while new operands are offered.
    do_op8(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.A        = 8'h11;
      bus8.B        = 8'h22;
      bus8.op_sub   = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d out_valid", k), bus8.out_valid, 1);
      chk($sformatf("bp%0d in_ready", k), bus8.in_ready, 0);
      chk($sformatf("bp%0d Sum", k), bus8.Sum, 8'h96);
      chk($sformatf("bp%0d Cout", k), bus8.Cout, 0);
      chk($sformatf("bp%0d Ovf", k), bus8.Ovf, 1);
    end
    @(negedge clk);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", bus8.out_valid, 0);
    chk("bp release in_ready", bus8.in_ready, 1);
    chk("bp release busy", bus8.busy, 0);
    @(posedge clk);
    #1;
    chk("bp no stray accept", bus8.busy, 0);
    chk("bp Sum kept", bus8.Sum, 8'h96);

    // Reset at bit_idx=3 aborts the operation.
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.op_sub   = 1'b0;
    bus8.A        = 8'h5A;
    bus8.B        = 8'h3C;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort bit_idx before reset", bus8.bit_idx, 3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort out_valid", bus8.out_valid, 0);
    chk("abort in_ready", bus8.in_ready, 1);
    chk("abort busy", bus8.busy, 0);
    chk("abort Sum", bus8.Sum, 0);
    chk("abort bit_idx", bus8.bit_idx, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort no late result", bus8.out_valid, 0);
    do_op8(1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1, "post-abort");

    // WIDTH=1: add 1+1.
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.op_sub   = 1'b0;
    bus1.A        = 1'b1;
    bus1.B        = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    chk("w1 add RUN out_valid", bus1.out_valid, 0);
    chk("w1 add RUN busy", bus1.busy, 1);
    @(posedge clk);
    #1;
    chk("w1 add out_valid", bus1.out_valid, 1);
    chk("w1 add Sum", bus1.Sum, 0);
    chk("w1 add Cout", bus1.Cout, 1);
    chk("w1 add Ovf", bus1.Ovf, 1);
    @(posedge clk);
    #1;
    chk("w1 add in_ready", bus1.in_ready, 1);

    // WIDTH=1: sub 0-1.
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.op_sub   = 1'b1;
    bus1.A        = 1'b0;
    bus1.B        = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w1 sub out_valid", bus1.out_valid, 1);
    chk("w1 sub Sum", bus1.Sum, 1);
    chk("w1 sub Cout", bus1.Cout, 0);
    chk("w1 sub Ovf", bus1.Ovf, 1);
    @(posedge clk);
    #1;
    chk("w1 sub idle", bus1.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bitserial_ctrl.md
Name: adder_bitserial_ctrl

Overview:
- Bit-serial add/subtract sequencer for PIM-style arithmetic. Drives one adder_1bit full-adder cell over WIDTH cycles, LSB first.
- Holds the carry in a flip-flop between cycles and assembles the WIDTH-bit result in a shift register.
- Sits between a requester (valid/ready operand handshake) and a consumer (valid/ready result handshake).
- Reference model for the bit-serial schedule the PIM backend emits for adder_nbit-class workloads.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH) (min 1), width of the bit counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  controller can accept operands.
- op_sub  in  1  0 = A+B, 1 = A-B; sampled with operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Sum  out  WIDTH  result, modulo 2^WIDTH.
- Cout  out  1  final carry out; for subtract, 1 = no borrow.
- Ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.
- bit_idx  out  CNT_W  bit currently being computed; 0 outside RUN.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; in_ready=1, out_valid=0, busy=0, bit_idx=0; Sum, Cout, Ovf = 0.
  - Reset mid-RUN or mid-DONE aborts the operation: no result is presented, and the pending result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - Accept on the edge where in_valid & in_ready.
  - On accept: latch A into opa_sr, latch B into opb_sr; if op_sub, latch ~B instead.
  - On accept: carry <= op_sub; cnt <= 0; Sum register <= 0; go to RUN.
  - No accept: stay in IDLE.
- RUN: in_ready=0; in_valid is ignored (no latch, no side effect).
  - Each cycle, the full-adder cell inputs are opa_sr[0], opb_sr[0] and carry.
  - Sum shift register shifts right, inserting the cell sum at bit WIDTH-1.
  - opa_sr and opb_sr shift right by one.
  - carry <= cell Cout; cnt <= cnt+1.
  - Keep prev_carry <= carry so the carry into the MSB is available.
  - On the edge where cnt==WIDTH-1: go to DONE; Cout <= cell Cout; Ovf <= carry XOR cell Cout (carry into MSB vs carry out).
- DONE: out_valid=1.
  - Sum, Cout and Ovf are held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On out_valid & out_ready: go to IDLE.
  - Sum, Cout and Ovf keep their values in IDLE until the next accept.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- Minimum initiation interval is WIDTH+2 cycles. No overlap: in_ready stays low in DONE, even in the cycle out_ready=1.
- WIDTH=1: a single RUN cycle; Ovf = cin XOR cout of that cycle.
- Arithmetic: Sum = (A + (op_sub ? ~B : B) + op_sub) mod 2^WIDTH.
  - No saturation.
  - Cout and Ovf are valid only while out_valid=1 or after it, until the next accept.
- bit_idx = cnt in RUN, 0 otherwise.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, add 0x5A+0x3C, out_ready=1 -> out_valid exactly 8 cycles after accept; Sum=0x96, Cout=0, Ovf=1; in_ready returns 1 one cycle after the handshake.
- WIDTH=8, add 0xFF+0x01 -> Sum=0x00, Cout=1, Ovf=0; carry-ripple wrap-around across all 8 serial steps; bit_idx sequence 0..7.
- WIDTH=8, sub 0x10-0x20 -> Sum=0xF0, Cout=0 (borrow), Ovf=0. Sub 0x80-0x01 -> Sum=0x7F, Cout=1, Ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, while pulsing in_valid with A=0x11, B=0x22 -> Sum/Cout/Ovf stable, in_ready=0, new operands not accepted; release -> one handshake, then IDLE.
- Reset mid-op: assert rst for 1 cycle at bit_idx=3 of 0x5A+0x3C -> next cycle IDLE, out_valid=0, Sum=0. Then 0x01+0x02 -> Sum=0x03 with no carry leaked from the aborted operation.
- WIDTH=1 instance: add 1+1 -> Sum=0, Cout=1, Ovf=1, out_valid 1 cycle after accept; sub 0-1 -> Sum=1, Cout=0, Ovf=1.
